// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and sizing helper for the UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Width of a counter that has to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with registered head outputs; head holds the last
// popped entry while the FIFO is empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_n;
  logic [AW:0]      rd_ptr_n;
  logic             do_push;
  logic             do_pop;
  logic             bypass;

  // Status flags and next pointers; a pop in the same cycle frees a full slot.
  always_comb begin
    empty_c  = (wr_ptr == rd_ptr);
    full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    do_pop   = pop && !empty_c;
    do_push  = push && (!full_c || do_pop);
    wr_ptr_n = do_push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    bypass   = do_push && (wr_ptr == rd_ptr_n);
  end

  // Storage, pointers and the registered head view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      head_valid <= (wr_ptr_n != rd_ptr_n);
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
      end
      if (wr_ptr_n != rd_ptr_n) begin
        head_data <= bypass ? push_data : mem[rd_ptr_n[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 2-of-3 mid-bit voting,
// optional parity, 1/2 stop bits, and a receive FIFO with valid/ready.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 reset_n,
  input  logic                 receive,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int unsigned CW  = cnt_width(CLKS_PER_BIT);
  localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned FW  = DATA_BITS + 2;
  localparam int unsigned IW  = 4;
  localparam logic        PAR_EXP = (PARITY == PAR_ODD);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frame_err;

  logic                 vote_c;
  logic                 mid_end_c;
  logic                 bit_end_c;
  logic                 push_c;
  logic                 pop_c;
  logic [FW-1:0]        push_word_c;
  logic                 full_c;
  logic                 empty_c;
  logic [FW-1:0]        head;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Capture the first two of the three votes around mid-bit.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      if (cnt == CW'(MID - 1)) s0 <= rx_s;
      if (cnt == CW'(MID))     s1 <= rx_s;
    end
  end

  // Majority vote, window strobes and the word handed to the FIFO.
  always_comb begin
    vote_c      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    mid_end_c   = (cnt == CW'(MID + 1));
    bit_end_c   = (cnt == CW'(CLKS_PER_BIT - 1));
    push_c      = (state == ST_STOP) && mid_end_c && (bit_idx == IW'(STOP_BITS - 1));
    push_word_c = {frame_err | ~vote_c, par_err, shreg};
    pop_c       = i_Rx_Ready & ~empty_c;
  end

  // Frame FSM with bit-period counter; all frame state registered here.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      o_Busy    <= 1'b0;
    end else begin
      if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
        cnt <= bit_end_c ? '0 : cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (receive && rx_s) state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!receive) begin
            state <= ST_IDLE;
          end else if (!rx_s) begin
            state     <= ST_START;
            cnt       <= '0;
            bit_idx   <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            o_Busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (mid_end_c && vote_c) begin
            state  <= ST_WAIT_START;
            o_Busy <= 1'b0;
          end else if (bit_end_c) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid_end_c) shreg <= {vote_c, shreg[DATA_BITS-1:1]};
          if (bit_end_c) begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (mid_end_c) par_err <= (((^shreg) ^ vote_c) != PAR_EXP);
          if (bit_end_c) state <= ST_STOP;
        end
        ST_STOP: begin
          if (mid_end_c && !vote_c) frame_err <= 1'b1;
          if (push_c) begin
            o_Busy <= 1'b0;
            // A framing error waits for the line to return high before re-arming.
            state  <= (frame_err || !vote_c || !receive) ? ST_IDLE : ST_WAIT_START;
          end else if (bit_end_c) begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overrun pulse: a completed word arrived while full with no pop.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      o_Overrun <= 1'b0;
    end else begin
      o_Overrun <= push_c && full_c && !pop_c;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_Clock),
    .rst_n      (reset_n),
    .push       (push_c),
    .push_data  (push_word_c),
    .pop        (pop_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .head_valid (o_Rx_Valid),
    .head_data  (head)
  );

  assign o_Rx_Byte    = head[DATA_BITS-1:0];
  assign o_Parity_Err = head[DATA_BITS];
  assign o_Frame_Err  = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (16 clk/bit, 8 data bits, even parity, 2 stop bits).
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DB    = 8;
  localparam int unsigned PAR   = 2;
  localparam int unsigned SB    = 2;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       receive;
  logic       rx;
  logic       ready;
  logic       valid;
  logic [7:0] rx_byte;
  logic       pe;
  logic       fe;
  logic       ov;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  int         ov_cycles = 0;
  int         ov_base;
  logic [9:0] exp_q[$];
  logic [9:0] mon_got;
  logic [9:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .PARITY       (PAR),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clock      (clk),
    .reset_n      (rst_n),
    .receive      (receive),
    .i_Rx_Serial  (rx),
    .o_Rx_Valid   (valid),
    .i_Rx_Ready   (ready),
    .o_Rx_Byte    (rx_byte),
    .o_Parity_Err (pe),
    .o_Frame_Err  (fe),
    .o_Overrun    (ov),
    .o_Busy       (busy)
  );

  // Monitor: every accepted word is compared with the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      mon_got = {fe, pe, rx_byte};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL word got={fe,pe,data}=%h required=%h", mon_got, mon_exp);
        end
      end
    end
    if (rst_n && ov) ov_cycles++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  // Start bit, 8 data bits LSB first (optional 1-cycle spike), parity, stop1=1, stop2.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s2, input int spike_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        rx = d[i];
        tick(7);
        rx = ~d[i];
        tick(1);
        rx = d[i];
        tick(CPB - 8);
      end else begin
        drive_bit(d[i]);
      end
    end
    drive_bit(p);
    drive_bit(1'b1);
    drive_bit(s2);
  endtask

  function automatic logic epar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending_words got=%0d required=0", name, exp_q.size());
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    receive = 1'b1;
    rx      = 1'b1;
    ready   = 1'b1;
    tick(3);
    @(negedge clk);
    check("reset_outputs", {valid, rx_byte, pe, fe, ov, busy}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // 1: plain word
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, epar(8'hA5), 1'b1, -1);
    tick(2 * CPB);
    wait_drain("t1_a5");
    @(negedge clk);
    check("t1_valid_low", valid, 1'b0);
    tick(1);

    // 2: parity error / parity ok
    exp_q.push_back({2'b01, 8'h03});
    send_frame(8'h03, 1'b1, 1'b1, -1);
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'h03});
    send_frame(8'h03, 1'b0, 1'b1, -1);
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, -1);
    tick(2 * CPB);
    wait_drain("t2_parity");

    // 3: second stop bit low, then line held low (break)
    exp_q.push_back({2'b10, 8'h5A});
    send_frame(8'h5A, epar(8'h5A), 1'b0, -1);
    rx = 1'b0;
    tick(20 * CPB);
    @(negedge clk);
    check("t3_busy_in_break", busy, 1'b0);
    tick(1);
    wait_drain("t3_frame_err");
    rx = 1'b1;
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'h11});
    send_frame(8'h11, epar(8'h11), 1'b1, -1);
    tick(2 * CPB);
    wait_drain("t3_after_break");

    // 4: stalled consumer, overrun on 5th word
    ready   = 1'b0;
    ov_base = ov_cycles;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({2'b00, 8'(i)});
      send_frame(8'(i), epar(8'(i)), 1'b1, -1);
      if (i == 4) begin
        @(negedge clk);
        check("t4_no_overrun_yet", ov_cycles - ov_base, 0);
        tick(1);
      end
      tick(CPB);
    end
    @(negedge clk);
    check("t4_overrun_cycles", ov_cycles - ov_base, 1);
    check("t4_valid_stalled", valid, 1'b1);
    check("t4_head_word", rx_byte, 8'h01);
    tick(1);
    ready = 1'b1;
    wait_drain("t4_drain");
    tick(2);
    @(negedge clk);
    check("t4_valid_after_drain", valid, 1'b0);
    tick(1);

    // 5: start glitch rejected; single-cycle spikes voted out
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    @(negedge clk);
    check("t5_busy_on_glitch", busy, 1'b1);
    tick(CPB);
    @(negedge clk);
    check("t5_busy_cleared", busy, 1'b0);
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'hF0});
    send_frame(8'hF0, epar(8'hF0), 1'b1, 2);
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'hF0});
    send_frame(8'hF0, epar(8'hF0), 1'b1, 5);
    tick(2 * CPB);
    wait_drain("t5_spike");

    // 6: reset mid-DATA, recovery, receive deasserted mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    check("t6_reset_outputs", {valid, rx_byte, pe, fe, ov, busy}, 32'h0);
    tick(1);
    rx    = 1'b1;
    rst_n = 1'b1;
    tick(2 * CPB);
    exp_q.push_back({2'b00, 8'hC3});
    send_frame(8'hC3, epar(8'hC3), 1'b1, -1);
    tick(2 * CPB);
    wait_drain("t6_c3");

    exp_q.push_back({2'b00, 8'h3C});
    fork
      send_frame(8'h3C, epar(8'h3C), 1'b1, -1);
      begin
        tick(5 * CPB);
        receive = 1'b0;
      end
    join
    tick(2 * CPB);
    wait_drain("t6_3c");
    fork
      send_frame(8'h77, epar(8'h77), 1'b1, -1);
      begin
        tick(3 * CPB);
        @(negedge clk);
        check("t6_ignored_busy", busy, 1'b0);
      end
    join
    tick(2 * CPB);
    @(negedge clk);
    check("t6_ignored_no_word", valid, 1'b0);
    check("t6_ignored_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver for the accelerator's host link.
- Configurable data width, parity mode and stop-bit count.
- Majority-vote mid-bit sampling.
- Per-word parity and framing error flags.
- Small receive FIFO with a valid/ready output, so the downstream command parser can stall without losing bytes.
- Sits between the board RX pin and the packet/command decoder.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per UART bit (clock freq / baud); must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of two >= 2

Ports:
i_Clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
receive  in  1  receive enable; level-sensitive
i_Rx_Serial  in  1  asynchronous serial input, idle high
o_Rx_Valid  out  1  FIFO head holds a word
i_Rx_Ready  in  1  consumer accepts head word when high together with o_Rx_Valid
o_Rx_Byte  out  DATA_BITS  head data word
o_Parity_Err  out  1  head word failed parity check (always 0 if PARITY=0)
o_Frame_Err  out  1  head word had a stop bit sampled low
o_Overrun  out  1  one-cycle pulse: completed word dropped because FIFO full
o_Busy  out  1  high from start-bit detect until frame end

Behaviour:
- Reset is asynchronous, active low, and applies to every flop. Reset values:
  - 2-FF synchroniser = 1
  - state = IDLE, counters = 0, FIFO empty
  - o_Rx_Valid = 0, o_Rx_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Overrun = 0, o_Busy = 0
- Input path: i_Rx_Serial passes through a 2-FF synchroniser. Only the synchronised value (rx_s) is used.
- Sampling: each bit is decided by 2-of-3 majority of rx_s at counter values M-1, M and M+1.
  - M = (CLKS_PER_BIT-1)/2.
  - The bit counter runs 0..CLKS_PER_BIT-1 within each bit period.
  - Bit-period counter width is $clog2(CLKS_PER_BIT).
- States:
  - IDLE: wait for receive=1 and rx_s=1 (line idle), then go to WAIT_START. While receive=0, stay in IDLE.
  - WAIT_START: on rx_s=0, clear counters, set o_Busy, go to START. If receive=0, go to IDLE.
  - START: at the end of the majority window, a vote of 1 is a false start: go to WAIT_START with no push. A vote of 0 continues to DATA, period aligned to the start-bit edge.
  - DATA: shift in DATA_BITS votes LSB first, one per bit period. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: parity error = XOR(data, parity bit) != expected. Expected is 1 for odd, 0 for even.
  - STOP: sample STOP_BITS stop bits. Any 0 vote sets frame error. At the mid-point window end of the final stop bit:
    - push {frame_err, parity_err, data} into the FIFO and clear o_Busy;
    - if frame_err, go to IDLE (requires the line to return high first; prevents break-condition retrigger);
    - otherwise go to WAIT_START.
- Latency: push occurs at the mid-point of the last stop bit, and o_Rx_Valid rises the following cycle.
- receive deasserted mid-frame: the current frame completes and is pushed, then the FSM goes to IDLE.
- FIFO:
  - Pop when o_Rx_Valid & i_Rx_Ready. Outputs show the head entry; when empty they hold the last popped value.
  - Push and pop in the same cycle are both honoured, including when full: a pop frees the slot, so no overrun.
  - Push when full and no pop: the new word is discarded and o_Overrun pulses for exactly 1 cycle. FIFO contents are unchanged.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with wrap-around via the MSB toggle.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state encodings (IDLE, WAIT_START, START, DATA, PARITY, STOP);
  - a function computing counter width.
- Natural sub-module: uart_rx_fifo (synchronous FIFO, parameters WIDTH and DEPTH, with full/empty and push/pop ports), instantiated with WIDTH = DATA_BITS+2.

Test Plan:
1. CLKS_PER_BIT=16, DATA_BITS=8, PARITY=0, receive=1; send 0xA5 with 1 stop bit, i_Rx_Ready=1 -> o_Rx_Valid pulses once, o_Rx_Byte=0xA5, both error flags 0.
2. PARITY=2 (even); send 0x03 with parity bit 1 -> o_Parity_Err=1, o_Rx_Byte=0x03. Resend with parity bit 0 -> o_Parity_Err=0.
3. STOP_BITS=2; send 0x5A with second stop bit low, then hold the line low for 20 bit periods -> one word 0x5A with o_Frame_Err=1. No further words until the line returns high and a new valid frame is sent.
4. i_Rx_Ready=0, FIFO_DEPTH=4; send 5 bytes 0x01..0x05 -> o_Overrun pulses 1 cycle on the 5th. Draining yields 0x01..0x04 in order, then o_Rx_Valid=0.
5. Start glitch: drive the line low for 4 cycles, then high -> no push, o_Busy returns to 0. A single-cycle spike mid-data-bit does not flip that bit (majority vote).
6. Deassert reset_n mid-DATA, then re-assert -> all outputs at reset values. Subsequent frame 0xC3 is received correctly. Deasserting receive mid-frame still delivers that frame, then ignores the next one.
